// File: rtl/cipher_ram_writer.sv
// cipher_ram_writer
//
// Takes one 128-bit ciphertext block through a valid/ready handshake and
// writes it out to a byte-wide RAM, one byte per cycle, at addresses 0..15
// (byte i = cipher_in[8i+7:8i] goes to address i). A one-cycle done pulse
// follows the 16th write, and then the block is ready for the next one.
// The full cycle takes 18 cycles per block: 1 handshake, 16 writes, 1 done.
//
// Optional feature, enabled by defining CIPHER_RAM_READBACK_EN:
//   an internal 16x8 copy of the RAM contents is written in parallel with
//   ram_we and read through rd_addr/rd_data, with one cycle of read latency.
//   The copy resets to all zero.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   cipher_in    in   [127:0] ciphertext block
//   cipher_valid in   cipher_in holds a valid block
//   cipher_ready out  block can be accepted this cycle (high only in IDLE)
//   ram_we       out  byte write strobe
//   ram_addr     out  [3:0] byte address (0 when not writing)
//   ram_wdata    out  [7:0] byte write data (0 when not writing)
//   done         out  one-cycle pulse after the 16th byte is written
//   busy         out  high while writing and during the done cycle
//   rd_addr      in   [3:0] readback address (CIPHER_RAM_READBACK_EN only)
//   rd_data      out  [7:0] registered readback data (CIPHER_RAM_READBACK_EN only)

module cipher_ram_writer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] cipher_in,
    input  logic         cipher_valid,
    output logic         cipher_ready,
    output logic         ram_we,
    output logic [3:0]   ram_addr,
    output logic [7:0]   ram_wdata,
    output logic         done,
    output logic         busy
`ifdef CIPHER_RAM_READBACK_EN
    ,
    input  logic [3:0]   rd_addr,
    output logic [7:0]   rd_data
`endif
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWrite = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [3:0]   index_q, index_d;
    logic [127:0] holding_q, holding_d;
    logic         handshake;

    assign handshake = cipher_valid && (state_q == StIdle);

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        holding_d = holding_q;
        case (state_q)
            StIdle: begin
                if (handshake) begin
                    holding_d = cipher_in;
                    index_d   = 4'd0;
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                // The index wraps to 0 on the last byte, but the FSM leaves
                // WRITE at the same edge, so address 0 is never rewritten.
                index_d = index_q + 4'd1;
                if (index_q == 4'd15) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            index_q   <= 4'd0;
            holding_q <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            holding_q <= holding_d;
        end
    end

    // Outputs decode directly from state, so the write address and data are
    // forced to zero outside WRITE instead of showing stale holding bytes.
    always_comb begin
        cipher_ready = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = 4'd0;
        ram_wdata    = 8'd0;
        done         = 1'b0;
        busy         = 1'b0;
        case (state_q)
            StIdle: begin
                cipher_ready = 1'b1;
            end
            StWrite: begin
                ram_we    = 1'b1;
                ram_addr  = index_q;
                ram_wdata = holding_q[{index_q, 3'b000} +: 8];
                busy      = 1'b1;
            end
            StDone: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                cipher_ready = 1'b0;
            end
        endcase
    end

`ifdef CIPHER_RAM_READBACK_EN
    logic [7:0] mem_q [16];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 8'd0;
            end
            rd_data_q <= 8'd0;
        end else begin
            if (ram_we) begin
                mem_q[ram_addr] <= ram_wdata;
            end
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule
